// File: rtl/silencer_ctl_pkg.sv
// Shared types and constants for the silencer control sequencing logic.
package silencer_ctl_pkg;

    typedef enum logic [1:0] {
        GUARD,
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    // The calculator divides by the completion step count, so it may never be zero.
    localparam logic [7:0] MIN_COMPLETION_STEPS = 8'd1;

    function automatic logic [7:0] clamp_steps(input logic [7:0] steps);
        return (steps < MIN_COMPLETION_STEPS) ? MIN_COMPLETION_STEPS : steps;
    endfunction

endpackage

// File: rtl/step_calc_sequencer.sv
// Streams one frame of DEPTH intensities into the intensity step calculator and
// waits for all of its results, with request queuing, overrun and timeout flags.
module step_calc_sequencer
    import silencer_ctl_pkg::*;
#(
    parameter int unsigned DEPTH   = 249,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UPDATE,
    input  logic [7:0] COMPLETION_STEPS_IN,
    output logic [7:0] ADDR,
    input  logic [7:0] INTENSITY_IN,
    output logic       DIN_VALID,
    output logic [7:0] INTENSITY,
    output logic [7:0] COMPLETION_STEPS,
    input  logic       CALC_DOUT_VALID,
    output logic       BUSY,
    output logic       DONE,
    output logic       OVERRUN,
    output logic       TIMEOUT_ERR,
    input  logic       ERR_CLR
);

    localparam int unsigned    TW        = $clog2(TIMEOUT + 1);
    localparam logic [8:0]     DEPTH_C   = 9'(DEPTH);
    localparam logic [8:0]     ADDR_LAST = 9'(DEPTH - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [8:0]    addr_cnt;
    logic [8:0]    res_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    steps_q;
    logic          pending;
    logic          din_valid_q;
    logic          overrun_q;
    logic          timeout_q;

    logic          busy;
    logic          tmo_last;
    logic          start;
    logic          done;
    logic          abandon;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        done       = 1'b0;
        abandon    = 1'b0;
        busy       = (state == FETCH) || (state == DRAIN);
        tmo_last   = (tmo_cnt == TMO_LAST);
        case (state)
            GUARD: if (tmo_last) state_next = IDLE;
            IDLE: begin
                if (UPDATE || pending) begin
                    start      = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: if (addr_cnt == ADDR_LAST) state_next = DRAIN;
            DRAIN: begin
                if (res_cnt == DEPTH_C) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (tmo_last) begin
                    abandon    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = GUARD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= GUARD;
            addr_cnt    <= '0;
            res_cnt     <= '0;
            tmo_cnt     <= '0;
            steps_q     <= MIN_COMPLETION_STEPS;
            pending     <= 1'b0;
            din_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_next;
            // Data for the address issued this cycle arrives next cycle.
            din_valid_q <= (state == FETCH);

            // One counter serves both the post-reset guard and the drain watchdog.
            if (state_next != state)
                tmo_cnt <= '0;
            else if ((state == GUARD) || (state == DRAIN))
                tmo_cnt <= tmo_cnt + 1'b1;

            if (start) begin
                addr_cnt <= '0;
                res_cnt  <= '0;
                steps_q  <= clamp_steps(COMPLETION_STEPS_IN);
            end else begin
                if ((state == FETCH) && (addr_cnt != ADDR_LAST))
                    addr_cnt <= addr_cnt + 9'd1;
                if (busy && CALC_DOUT_VALID && (res_cnt != DEPTH_C))
                    res_cnt <= res_cnt + 9'd1;
            end

            if (start)
                pending <= 1'b0;
            else if (UPDATE && ((state == GUARD) || busy))
                pending <= 1'b1;

            overrun_q <= (overrun_q & ~ERR_CLR) | (UPDATE & busy & pending);
            timeout_q <= (timeout_q & ~ERR_CLR) | abandon;
        end
    end

    assign ADDR             = addr_cnt[7:0];
    assign DIN_VALID        = din_valid_q;
    assign INTENSITY        = INTENSITY_IN;
    assign COMPLETION_STEPS = steps_q;
    assign BUSY             = busy;
    assign DONE             = done;
    assign OVERRUN          = overrun_q;
    assign TIMEOUT_ERR      = timeout_q;

endmodule

// File: tb/tb_step_calc_sequencer.sv
// Randomized bench for step_calc_sequencer against a frame-timing reference model.
module tb_step_calc_sequencer;

    localparam int DEPTH   = 249;
    localparam int TIMEOUT = 32;
    localparam int SCHED_N = 16384;

    logic       CLK;
    logic       RST;
    logic       UPDATE;
    logic [7:0] COMPLETION_STEPS_IN;
    logic [7:0] ADDR;
    logic [7:0] INTENSITY_IN;
    logic       DIN_VALID;
    logic [7:0] INTENSITY;
    logic [7:0] COMPLETION_STEPS;
    logic       CALC_DOUT_VALID;
    logic       BUSY;
    logic       DONE;
    logic       OVERRUN;
    logic       TIMEOUT_ERR;
    logic       ERR_CLR;

    step_calc_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .UPDATE              (UPDATE),
        .COMPLETION_STEPS_IN (COMPLETION_STEPS_IN),
        .ADDR                (ADDR),
        .INTENSITY_IN        (INTENSITY_IN),
        .DIN_VALID           (DIN_VALID),
        .INTENSITY           (INTENSITY),
        .COMPLETION_STEPS    (COMPLETION_STEPS),
        .CALC_DOUT_VALID     (CALC_DOUT_VALID),
        .BUSY                (BUSY),
        .DONE                (DONE),
        .OVERRUN             (OVERRUN),
        .TIMEOUT_ERR         (TIMEOUT_ERR),
        .ERR_CLR             (ERR_CLR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] ram [256];
    bit         sched [SCHED_N];
    logic [7:0] last_addr = '0;

    // Reference model: a frame is described by the cycle m_ts in which it was
    // accepted; every window (fetch, data valid, drain, deadline) is an offset from it.
    bit         m_frame = 0;
    int         m_ts    = 0;
    int         m_res   = 0;
    bit         m_pend  = 0;
    bit         m_ovr   = 0;
    bit         m_tmo   = 0;
    int         m_guard = 0;
    bit         m_addr_zero = 1;
    logic [7:0] m_steps = 8'd1;

    bit exp_done    = 0;
    bit exp_abandon = 0;
    bit exp_din     = 0;

    int cfg_lat  = 8;
    int cfg_resp = DEPTH;
    int resp_n   = 0;
    bit rand_cfg = 0;
    bit noise_en = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_advance();
        bit busy;
        bit guard;
        bit idle;
        if (RST) begin
            m_frame = 0; m_pend = 0; m_ovr = 0; m_tmo = 0; m_res = 0;
            m_steps = 8'd1; m_guard = TIMEOUT; m_addr_zero = 1;
        end else begin
            busy  = m_frame;
            guard = (m_guard > 0);
            idle  = !busy && !guard;
            m_ovr = (m_ovr && !ERR_CLR) || (UPDATE && busy && m_pend);
            m_tmo = (m_tmo && !ERR_CLR) || exp_abandon;
            if (busy && CALC_DOUT_VALID && m_res < DEPTH) m_res++;
            if (idle && (UPDATE || m_pend)) begin
                m_ts = cyc; m_frame = 1; m_res = 0; m_pend = 0; m_addr_zero = 0;
                m_steps = (COMPLETION_STEPS_IN == 8'd0) ? 8'd1 : COMPLETION_STEPS_IN;
                resp_n = 0;
                if (rand_cfg) begin
                    cfg_lat  = $urandom_range(1, 20);
                    cfg_resp = ($urandom_range(0, 3) == 0) ? $urandom_range(150, DEPTH - 1) : DEPTH;
                end
            end else if (UPDATE && (guard || busy)) begin
                m_pend = 1;
            end
            if (guard) m_guard--;
            if (exp_done || exp_abandon) m_frame = 0;
        end
    endtask

    task automatic check_outputs();
        int drain_start;
        drain_start = m_ts + DEPTH + 1;
        exp_done    = m_frame && (cyc >= drain_start) && (m_res == DEPTH);
        exp_abandon = m_frame && !exp_done && (cyc == drain_start + TIMEOUT - 1);
        exp_din     = m_frame && (cyc >= m_ts + 2) && (cyc <= m_ts + DEPTH + 1);
        check("busy", BUSY, m_frame);
        check("done", DONE, exp_done);
        check("din_valid", DIN_VALID, exp_din);
        check("steps", COMPLETION_STEPS, m_steps);
        check("overrun", OVERRUN, m_ovr);
        check("timeout_err", TIMEOUT_ERR, m_tmo);
        if (m_frame && cyc <= m_ts + DEPTH)
            check("addr", ADDR, cyc - m_ts - 1);
        else if (m_addr_zero)
            check("addr_rst", ADDR, 0);
        if (exp_din)
            check("intensity", INTENSITY, ram[cyc - m_ts - 2]);
    endtask

    task automatic tick();
        bit noise;
        model_advance();
        @(posedge CLK);
        #1;
        cyc++;
        INTENSITY_IN = ram[last_addr];
        check_outputs();
        last_addr = ADDR;
        if (exp_din && resp_n < cfg_resp && cyc + cfg_lat < SCHED_N) begin
            sched[cyc + cfg_lat] = 1;
            resp_n++;
        end
        noise = noise_en && !m_frame && ($urandom_range(0, 3) == 0);
        CALC_DOUT_VALID = (cyc < SCHED_N && sched[cyc]) || noise;
    endtask

    task automatic pulse_update();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while ((m_frame || m_pend || m_guard > 0) && n < max_cycles) begin
            tick();
            n++;
        end
        if (m_frame || m_pend || m_guard > 0) check("idle_wait", 1, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        RST = 1'b1; UPDATE = 1'b0; ERR_CLR = 1'b0; CALC_DOUT_VALID = 1'b0;
        COMPLETION_STEPS_IN = 8'd0; INTENSITY_IN = 8'd0;

        repeat (3) tick();
        RST = 1'b0;
        noise_en = 1;
        wait_idle(100);
        repeat (5) tick();

        // Single full frame, response latency 8.
        COMPLETION_STEPS_IN = 8'd10;
        pulse_update();
        wait_idle(600);
        repeat (4) tick();

        // Zero steps forced to 1; mid-frame change only takes effect next frame.
        COMPLETION_STEPS_IN = 8'd0;
        pulse_update();
        repeat (50) tick();
        COMPLETION_STEPS_IN = 8'd20;
        wait_idle(600);
        repeat (5) tick();
        pulse_update();
        wait_idle(600);

        // Two requests during fetch: one pending, one overrun.
        pulse_update();
        repeat (30) tick();
        pulse_update();
        repeat (40) tick();
        pulse_update();
        wait_idle(1200);
        repeat (3) tick();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        repeat (3) tick();

        // Short response count -> timeout, then a normal frame.
        cfg_resp = 200;
        pulse_update();
        wait_idle(600);
        cfg_resp = DEPTH;
        repeat (3) tick();
        pulse_update();
        wait_idle(600);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;

        // Request in the DONE cycle queues the next frame.
        pulse_update();
        n = 0;
        while (!exp_done && n < 600) begin tick(); n++; end
        if (!exp_done) check("done_wait", 1, 0);
        pulse_update();
        wait_idle(1200);

        // Reset mid-fetch at address 100, request held through guard.
        pulse_update();
        n = 0;
        while (!(m_frame && cyc == m_ts + 101) && n < 400) begin tick(); n++; end
        if (!(m_frame && cyc == m_ts + 101)) check("addr100_wait", 1, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat ($urandom_range(0, 25)) tick();
        pulse_update();
        wait_idle(700);

        // Random traffic.
        rand_cfg = 1;
        for (int i = 0; i < 5000; i++) begin
            UPDATE  = ($urandom_range(0, 149) == 0);
            ERR_CLR = ($urandom_range(0, 199) == 0);
            RST     = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 49) == 0)
                COMPLETION_STEPS_IN = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            tick();
        end
        UPDATE = 1'b0; ERR_CLR = 1'b0; RST = 1'b0;
        wait_idle(1200);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
